// File: rtl/calc_ctrl_param_pkg.sv
// Shared encodings for the lab calculator controller: FSM states and operator codes.
package calc_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT_B = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MUL    = 3'd3,
      ST_FIN    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2
   } op_t;

endpackage

// File: rtl/calc_ctrl_param_if.sv
// Button/operand inputs and display/status outputs of the calculator controller.
interface calc_ctrl_param_if #(parameter int W = 8);

   logic           btn_a;
   logic           btn_s;
   logic           btn_m;
   logic           btn_e;
   logic           abort;
   logic [W-1:0]   num_in;
   logic [2*W-1:0] disp;
   logic           done;
   logic           busy;
   logic           neg;
   logic [2:0]     state;

   modport master (
      output btn_a, btn_s, btn_m, btn_e, abort, num_in,
      input  disp, done, busy, neg, state
   );

   modport slave (
      input  btn_a, btn_s, btn_m, btn_e, abort, num_in,
      output disp, done, busy, neg, state
   );

endinterface

// File: rtl/calc_ctrl_param_mul.sv
// Sequential shift-add multiplier: one partial-product iteration per cycle over W cycles.
module shift_add_mul #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           clr_n,
   input  logic           abort,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic [2*W-1:0] product,
   output logic           last
);

   localparam int CW = $clog2(W) + 1;

   logic [2*W:0]  p_r;
   logic [2*W:0]  p_add_s;
   logic [2*W:0]  p_nxt_s;
   logic [W:0]    sum_s;
   logic [CW-1:0] cnt_r;
   logic          busy_r;

   // Conditional add of A into the upper half, then shift right in the same cycle.
   always_comb begin
      sum_s = {1'b0, p_r[2*W-1:W]} + {1'b0, a};
      if (p_r[0]) begin
         p_add_s = {sum_s, p_r[W-1:0]};
      end else begin
         p_add_s = p_r;
      end
      p_nxt_s = p_add_s >> 1;
   end

   assign last    = busy_r && (cnt_r == CW'(W - 1));
   assign busy    = busy_r;
   assign product = p_r[2*W-1:0];

   // Product register, iteration counter and run flag.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         p_r    <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
      end else if (abort) begin
         p_r    <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
      end else if (start) begin
         p_r    <= {{(W+1){1'b0}}, b};
         cnt_r  <= '0;
         busy_r <= 1'b1;
      end else if (busy_r) begin
         p_r    <= p_nxt_s;
         cnt_r  <= cnt_r + CW'(1);
         busy_r <= !last;
      end else begin
         p_r    <= p_r;
         cnt_r  <= cnt_r;
         busy_r <= 1'b0;
      end
   end

endmodule

// File: rtl/calc_ctrl_param.sv
// Calculator controller: operand entry FSM, one-cycle add/|sub|, sequenced shift-add multiply.
module calc_ctrl_param
   import calc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic              clk,
   input  logic              clr_n,
   calc_ctrl_param_if.slave  bus
);

   state_t         state_r, state_nxt_s;
   op_t            op_r, op_nxt_s;
   logic [W-1:0]   a_r, a_nxt_s;
   logic [W-1:0]   b_r, b_nxt_s;
   logic [2*W-1:0] disp_r, disp_nxt_s;
   logic           done_r, done_nxt_s;
   logic           neg_r, neg_nxt_s;
   logic           busy_r, busy_nxt_s;
   logic           mul_start_s;
   logic           mul_busy_s;
   logic           mul_last_s;
   logic [2*W-1:0] mul_prod_s;
   logic [W:0]     sum_s;

   shift_add_mul #(.W(W)) u_mul (
      .clk     (clk),
      .clr_n   (clr_n),
      .abort   (bus.abort),
      .start   (mul_start_s),
      .a       (a_r),
      .b       (bus.num_in),
      .busy    (mul_busy_s),
      .product (mul_prod_s),
      .last    (mul_last_s)
   );

   assign sum_s = {1'b0, a_r} + {1'b0, b_r};

   // Next-state and next-output decode; abort overrides every button.
   always_comb begin
      state_nxt_s = state_r;
      op_nxt_s    = op_r;
      a_nxt_s     = a_r;
      b_nxt_s     = b_r;
      disp_nxt_s  = disp_r;
      neg_nxt_s   = neg_r;
      done_nxt_s  = 1'b0;
      mul_start_s = 1'b0;
      if (bus.abort) begin
         state_nxt_s = ST_IDLE;
         disp_nxt_s  = '0;
         neg_nxt_s   = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.btn_m) begin
                  op_nxt_s    = OP_MUL;
                  a_nxt_s     = bus.num_in;
                  state_nxt_s = ST_WAIT_B;
               end else if (bus.btn_a) begin
                  op_nxt_s    = OP_ADD;
                  a_nxt_s     = bus.num_in;
                  state_nxt_s = ST_WAIT_B;
               end else if (bus.btn_s) begin
                  op_nxt_s    = OP_SUB;
                  a_nxt_s     = bus.num_in;
                  state_nxt_s = ST_WAIT_B;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_WAIT_B: begin
               disp_nxt_s = {{W{1'b0}}, bus.num_in};
               if (bus.btn_e) begin
                  b_nxt_s = bus.num_in;
                  if (op_r == OP_MUL) begin
                     mul_start_s = 1'b1;
                     state_nxt_s = ST_MUL;
                  end else begin
                     state_nxt_s = ST_EXEC;
                  end
               end else begin
                  state_nxt_s = ST_WAIT_B;
               end
            end
            ST_EXEC: begin
               if (op_r == OP_ADD) begin
                  disp_nxt_s = {{(W-1){1'b0}}, sum_s};
                  neg_nxt_s  = 1'b0;
               end else if (a_r >= b_r) begin
                  disp_nxt_s = {{W{1'b0}}, a_r - b_r};
                  neg_nxt_s  = 1'b0;
               end else begin
                  disp_nxt_s = {{W{1'b0}}, b_r - a_r};
                  neg_nxt_s  = 1'b1;
               end
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            ST_MUL: begin
               if (mul_last_s) begin
                  state_nxt_s = ST_FIN;
               end else begin
                  state_nxt_s = ST_MUL;
               end
            end
            ST_FIN: begin
               disp_nxt_s  = mul_prod_s;
               neg_nxt_s   = 1'b0;
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
      busy_nxt_s = (state_nxt_s == ST_EXEC) || (state_nxt_s == ST_MUL) || (state_nxt_s == ST_FIN);
   end

   // State, operand and output registers.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_r <= ST_IDLE;
         op_r    <= OP_ADD;
         a_r     <= '0;
         b_r     <= '0;
         disp_r  <= '0;
         done_r  <= 1'b0;
         neg_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         op_r    <= op_nxt_s;
         a_r     <= a_nxt_s;
         b_r     <= b_nxt_s;
         disp_r  <= disp_nxt_s;
         done_r  <= done_nxt_s;
         neg_r   <= neg_nxt_s;
         busy_r  <= busy_nxt_s;
      end
   end

   assign bus.disp  = disp_r;
   assign bus.done  = done_r;
   assign bus.neg   = neg_r;
   assign bus.busy  = busy_r;
   assign bus.state = state_r;

endmodule
